// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [1:0] MULT  = 2'd0;
    localparam logic [1:0] MULTU = 2'd1;
    localparam logic [1:0] DIV   = 2'd2;
    localparam logic [1:0] DIVU  = 2'd3;

    localparam int ITER_DEF = 32;

    // Quotient reported when the divisor is zero.
    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One multiply (shift-add) or divide (restoring) iteration around a single 33-bit adder.
module muldiv_step (
    input  logic        is_div,
    input  logic [31:0] acc,
    input  logic [31:0] opnd,
    input  logic [31:0] low,
    output logic [31:0] acc_nxt,
    output logic [31:0] low_nxt
);

    logic [32:0] add_a;
    logic [32:0] add_b;
    logic [32:0] sum;
    logic        cin;

    // Divide reuses the adder as rem - divisor via inverted operand plus carry-in.
    always_comb begin
        if (is_div) begin
            add_a = {acc, low[31]};
            add_b = ~{1'b0, opnd};
            cin   = 1'b1;
        end else begin
            add_a = {1'b0, acc};
            add_b = low[0] ? {1'b0, opnd} : 33'd0;
            cin   = 1'b0;
        end
        sum = add_a + add_b + {32'd0, cin};
    end

    // Shifted remainder is below twice the divisor, so sum[32] is a clean borrow.
    always_comb begin
        if (is_div) begin
            acc_nxt = sum[32] ? add_a[31:0] : sum[31:0];
            low_nxt = {low[30:0], ~sum[32]};
        end else begin
            acc_nxt = sum[32:1];
            low_nxt = {sum[0], low[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle 32-bit multiply/divide sequencer with HI/LO result registers.
// Signed MULT/DIV handling is enabled by defining MULDIV_SIGNED_EN.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          is_div;
    logic [31:0]   acc;
    logic [31:0]   opnd;
    logic [31:0]   low;
    logic [31:0]   acc_nxt;
    logic [31:0]   low_nxt;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;

`ifdef MULDIV_SIGNED_EN
    logic sgn_op;
    logic neg_q;
    logic neg_r;

    assign sgn_op = ~op[0];
    assign a_mag  = (sgn_op && a[31]) ? -a : a;
    assign b_mag  = (sgn_op && b[31]) ? -b : b;
`else
    logic unused_op0;

    assign unused_op0 = op[0];
    assign a_mag      = a;
    assign b_mag      = b;
`endif

    muldiv_step u_step (
        .is_div  (is_div),
        .acc     (acc),
        .opnd    (opnd),
        .low     (low),
        .acc_nxt (acc_nxt),
        .low_nxt (low_nxt)
    );

    // On divide-by-zero, low still holds the raw dividend.
    always_comb begin
        res_hi = acc;
        res_lo = low;
        if (div_zero) begin
            res_hi = low;
            res_lo = DIV_ZERO_Q;
        end
`ifdef MULDIV_SIGNED_EN
        else if (is_div) begin
            if (neg_q) res_lo = -low;
            if (neg_r) res_hi = -acc;
        end else if (neg_q) begin
            {res_hi, res_lo} = -{acc, low};
        end
`endif
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            acc      <= '0;
            opnd     <= '0;
            low      <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        is_div <= op[1];
                        acc    <= '0;
                        cnt    <= '0;
`ifdef MULDIV_SIGNED_EN
                        neg_q  <= sgn_op & (a[31] ^ b[31]);
                        neg_r  <= sgn_op & a[31];
`endif
                        if (op[1] && (b == 32'd0)) begin
                            div_zero <= 1'b1;
                            low      <= a;
                            state    <= FIX;
                        end else begin
                            div_zero <= 1'b0;
                            low      <= op[1] ? a_mag : b_mag;
                            opnd     <= op[1] ? b_mag : a_mag;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    low <= low_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(ITER - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle 32-bit multiply/divide sequencer for the CPU execute stage. Iterates a single 32-bit add/subtract step 32 times (shift-add multiply, restoring divide) under a small FSM. Holds results in HI/LO registers for the pipeline to read. Stalls the pipeline through `busy`.

## Interface
Parameters:
- `ITER`, 32: iteration count; equals operand width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `a`  in  32  multiplicand / dividend.
- `b`  in  32  multiplier / divisor.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO are updated.
- `div_zero`  out  1  sticky flag for the last op; set on divide by zero.
- `hi`  out  32  product[63:32] or remainder.
- `lo`  out  32  product[31:0] or quotient.

## Operation
- Reset (async, `reset`=0): state IDLE, counter 0. `busy`, `done`, `div_zero` = 0. `hi`, `lo` = 0.
- FSM states: IDLE, CALC, FIX.
- IDLE + `start`:
  - Latch `op`.
  - Latch operand magnitudes: abs(a), abs(b) for signed ops, raw values for unsigned ops.
  - Latch result signs: product/quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Go to CALC with counter=0 and `div_zero` cleared.
- IDLE + `start` on a DIV/DIVU with b==0: go straight to FIX with `div_zero`=1. No iterations run.
- CALC, multiply, one step per cycle:
  - If acc_lo[0]=1, add the multiplicand to acc_hi; the carry is kept as bit 32.
  - Shift {carry, acc_hi, acc_lo} right by 1.
- CALC, divide, one step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem − divisor, computed as a 33-bit subtraction.
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise rem is kept and quo[0] = 0.
- CALC exits to FIX when counter == ITER−1, after that cycle's step.
- FIX, one cycle: write `hi`/`lo`, pulse `done`, return to IDLE.
  - Signed multiply with negative sign: the 64-bit product is two's-complement negated.
  - Signed divide: the quotient is negated per quotient sign; the remainder is negated per remainder sign.
  - Divide by zero: `hi` = a, `lo` = 32'hFFFFFFFF.
- Signed DIV 0x80000000 / 0xFFFFFFFF yields lo = 0x80000000, hi = 0. This is wrap-around, with no flag.
- `start` while `busy` is ignored. No queueing.
- `hi`/`lo` hold their value until the next FIX.

## Timing
- `start` is accepted at edge E0.
- `busy` = 1 from after E0 until the edge that leaves FIX.
- Normal op: iterations run on E1..E32, FIX is evaluated on E33. New `hi`/`lo` and `done`=1 are visible in the cycle after E33. Latency is 33 cycles.
- Divide by zero: FIX on E1, so `done` follows E1. Latency is 1 cycle.
- `done` is a registered output, high for exactly one cycle. `busy` is 0 in that same cycle.
- Back-to-back: `start` asserted in the `done` cycle is accepted, so E0 of the next op is that edge.
- Reset asserted mid-operation aborts immediately; no `done` is produced.

## Configuration
- Macro `MULDIV_SIGNED_EN`.
- Defined: MULT/DIV perform signed magnitude conversion and sign correction as above.
- Undefined: the signed opcodes execute exactly as MULTU/DIVU. The abs/negate logic is removed. Latency is unchanged.

## Structure
- Shared package `muldiv_pkg`:
  - op encoding constants (MULT, MULTU, DIV, DIVU);
  - FSM state enum (IDLE, CALC, FIX);
  - `ITER` default;
  - divide-by-zero result constant 32'hFFFFFFFF.
- One sub-module, `muldiv_step`: a combinational single-iteration datapath. It takes mode, acc/rem, multiplicand/divisor and low register, and returns the next acc/rem and low register. It contains the one 33-bit add/subtract.
- FSM, counter, sign handling and output registers stay in `muldiv_unit`.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles: hi=0xFFFFFFFE, lo=0x00000001, one-cycle `done`.
- MULT a=−3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=−7, b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU a=100, b=0 → `done` after 1 cycle: div_zero=1, hi=100, lo=0xFFFFFFFF.
  - A subsequent DIVU 100/7 clears div_zero and gives lo=14, hi=2.
- `start` pulsed every cycle during an op → ignored, single `done`.
  - `start` in the `done` cycle → second op's `done` exactly 33 cycles later.
- `reset` dropped at cycle 10 of a MULTU → all outputs 0 immediately, no `done`, IDLE accepts a new `start` after release.
